sha_result_checker: RTL
=======================

# sha_result_checker

Sits directly downstream of the last pipelined SHA core in each processor slice. Takes one double-hash per cycle plus its valid/newblock tags and the difficulty word, and reconstructs the nonce that produced each hash from this processor's stride. Checks the hash against the difficulty target. Queues winning (nonce, block id) pairs in a small FIFO drained through a valid/ready handshake.

## Interface

Parameters:

- PROCESSORINDEX, 0: nonce of the first hash after a newblock.
- NUMPROCESSORS, 1: nonce stride between consecutive valid hashes.
- FIFO_DEPTH, 4: result queue entries; power of two, 2..16.
- BLOCKID_WIDTH, 8: width of the block id tag.

Ports (clock and reset first):

- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- valid_i, in, 1: doublehash and newblock_i are meaningful this cycle.
- newblock_i, in, 1: this hash is the first of a new block; qualified by valid_i.
- doublehash, in, HashState: final double SHA-256 state, words a..h.
- difficulty, in, 32: target word; sampled in the same cycle as valid_i.
- result_valid, out, 1: FIFO head holds a hit.
- result_ready, in, 1: consumer accepts the head this cycle.
- result_nonce, out, 32: nonce of the head entry.
- result_blockid, out, BLOCKID_WIDTH: block id of the head entry.
- overflow, out, 1: sticky; a hit was dropped.
- exhausted, out, 1: the nonce space for the current block has wrapped.
- hash_count, out, 32: valid hashes seen since the last newblock, including that newblock hash; saturates at 2^32-1.

## Operation

Nonce tracking:

- The internal register nonce_next holds the nonce of the next valid hash.
- valid_i && newblock_i:
  - The hash's nonce is PROCESSORINDEX.
  - nonce_next becomes PROCESSORINDEX+NUMPROCESSORS.
  - block_id increments, wrapping mod 2^BLOCKID_WIDTH.
  - hash_count becomes 1.
  - exhausted clears.
- valid_i && !newblock_i:
  - The hash's nonce is nonce_next.
  - nonce_next becomes nonce_next+NUMPROCESSORS, mod 2^32.
  - hash_count increments, saturating.
  - If the 33-bit sum carries out, exhausted is set.
- !valid_i: no state change; newblock_i is ignored.

Hit test, evaluated on valid_i only:

- Hit iff doublehash.h == 32'h0 and bswap32(doublehash.g) <= difficulty, unsigned.
- bswap32 reverses byte order.

Pipeline:

- Stage 1 registers hit, nonce and block_id. The block_id used is the updated value when newblock_i is high.
- Stage 2 pushes the entry into the FIFO if hit.

FIFO:

- Push occurs when the stage-1 hit register is set. Pop occurs when result_valid && result_ready.
- Push and pop in the same cycle while full: both happen, and there is no overflow.
- Push while full without a pop: the entry is dropped, and overflow sets and stays set until rst.
- Pop while empty: ignored.
- result_nonce and result_blockid are don't-care when result_valid=0 but must not be X after reset; they reset to 0.
- The FIFO is not flushed on newblock. Entries from old blocks stay queued, and the consumer filters them by block_id.

Reset values (rst sampled high at a clock edge):

- result_valid=0, result_nonce=0, result_blockid=0, overflow=0, exhausted=0, hash_count=0.
- FIFO empty, stage-1 register cleared.
- nonce_next=PROCESSORINDEX, block_id=0.
- rst has priority over every simultaneous event.

## Timing

- valid_i hit in cycle t: stage-1 register is valid in t+1, and the entry is at the FIFO output in t+2.
  - When the FIFO was empty, result_valid rises in cycle t+2.
  - Hit-to-output latency is 2 cycles.
- Pop in cycle t: the next entry, or result_valid=0, is presented in t+1.
- No combinational path from result_ready to result_valid.
- hash_count, exhausted and block_id update on the edge that samples valid_i (visible in t+1).
- Throughput: one hash per cycle indefinitely, with no backpressure to the SHA core. Hits beyond FIFO capacity are dropped and flagged.
- rst asserted mid-stream: all in-flight stage-1 and FIFO contents are discarded, and outputs are at reset values in the cycle after the rst edge.

## Test plan

- Reset values: with PROCESSORINDEX=3, NUMPROCESSORS=4, assert rst for 2 cycles.
  - Stimulus: valid_i=1, newblock_i=1, h=0, g=0, difficulty=0.
  - Expected: result_valid=1 two cycles later, result_nonce=3, result_blockid=1, hash_count=1.
- Nonce stride and bswap compare:
  - Stimulus: newblock, then 5 non-hit hashes, then a hash with h=0, g=32'h00FF0000, difficulty=32'h0000FF00.
  - Expected: hit with nonce=3+6*4=27. The same hash with difficulty=32'h0000FEFF gives no hit.
- FIFO overflow: 6 consecutive hits with FIFO_DEPTH=4 and result_ready=0.
  - Expected: 4 entries queued, overflow=1.
  - Then assert result_ready continuously; the entries drain in order, and result_valid=0 after 4 pops.
- Full FIFO with simultaneous push and pop:
  - Expected: occupancy stays at 4, overflow stays 0, and order is preserved.
- Nonce wrap:
  - Stimulus: force nonce_next near 2^32 with NUMPROCESSORS=4 and nonce_next=32'hFFFFFFFC, then apply one valid hash.
  - Expected: nonce 32'hFFFFFFFC, exhausted=1 next cycle, nonce_next=0.
  - Follow-up: the next newblock clears exhausted and restarts the nonce at PROCESSORINDEX.
- Mid-stream reset: assert rst one cycle after a hit.
  - Expected: no result emerges, result_valid=0, block_id=0, and the next newblock produces result_blockid=1.

Source files
------------

// File: rtl/sha_result_if.sv
// sha_result_if
//   Result stream leaving a SHA processor slice: one winning (nonce, block id)
//   pair per accepted transfer, valid/ready handshake.
//
//   result_valid   : producer has an entry at the head of its queue
//   result_ready   : consumer accepts the head entry this cycle
//   result_nonce   : nonce of the head entry
//   result_blockid : block id tag of the head entry
//
//   master = producer (the result checker), slave = consumer.
interface sha_result_if #(
    parameter int BLOCKID_WIDTH = 8
) ();
    logic                     result_valid;
    logic                     result_ready;
    logic [31:0]              result_nonce;
    logic [BLOCKID_WIDTH-1:0] result_blockid;

    modport master (
        output result_valid,
        output result_nonce,
        output result_blockid,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_nonce,
        input  result_blockid,
        output result_ready
    );
endinterface

// File: rtl/sha_result_checker.sv
// sha_result_checker
//   Sits behind the last pipelined SHA core of a processor slice. Rebuilds
//   the nonce of every valid hash from this processor's stride, tests the
//   hash against the difficulty word and queues hits in a small FIFO.
//
//   clk, rst     : single clock, synchronous active-high reset
//   valid_i      : doublehash / newblock_i meaningful this cycle
//   newblock_i   : first hash of a new block (qualified by valid_i)
//   doublehash   : final state, words a..h packed a = [255:224] ... h = [31:0]
//   difficulty   : target word, sampled together with valid_i
//   res          : result stream (valid/ready, nonce, block id)
//   overflow     : sticky, a hit was dropped because the queue was full
//   exhausted    : nonce space of the current block has wrapped
//   hash_count   : valid hashes since last newblock (incl. it), saturating
module sha_result_checker #(
    parameter logic [31:0] PROCESSORINDEX = 32'd0,
    parameter logic [31:0] NUMPROCESSORS  = 32'd1,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          BLOCKID_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               newblock_i,
    input  logic [255:0]       doublehash,
    input  logic [31:0]        difficulty,
    sha_result_if.master       res,
    output logic               overflow,
    output logic               exhausted,
    output logic [31:0]        hash_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0]              nonce_next;
    logic [BLOCKID_WIDTH-1:0] block_id;

    logic [31:0] word_g;
    logic [31:0] word_h;
    logic        unused_words;

    assign word_h = doublehash[31:0];
    assign word_g = doublehash[63:32];
    // Words a..f carry no information for the target test.
    assign unused_words = ^doublehash[255:64];

    // ---- stage 0: hit test and nonce reconstruction ----
    logic                     vld_p0;
    logic [31:0]              nonce_p0;
    logic [BLOCKID_WIDTH-1:0] blockid_p0;
    logic [32:0]              stride_sum;

    assign vld_p0     = valid_i && (word_h == 32'd0) && (bswap32(word_g) <= difficulty);
    assign nonce_p0   = newblock_i ? PROCESSORINDEX : nonce_next;
    // A newblock hash is tagged with the block id it starts, not the old one.
    assign blockid_p0 = newblock_i ? block_id + BLOCKID_WIDTH'(1) : block_id;
    // Carry out of this sum marks the nonce space wrapping within a block.
    assign stride_sum = {1'b0, nonce_next} + {1'b0, NUMPROCESSORS};

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_next <= PROCESSORINDEX;
            block_id   <= '0;
            hash_count <= 32'd0;
            exhausted  <= 1'b0;
        end else if (valid_i) begin
            if (newblock_i) begin
                nonce_next <= PROCESSORINDEX + NUMPROCESSORS;
                block_id   <= blockid_p0;
                hash_count <= 32'd1;
                exhausted  <= 1'b0;
            end else begin
                nonce_next <= stride_sum[31:0];
                hash_count <= sat_inc32(hash_count);
                if (stride_sum[32]) begin
                    exhausted <= 1'b1;
                end
            end
        end
    end

    // ---- stage 1: registered hit, nonce and block id ----
    logic                     vld_p1;
    logic [31:0]              nonce_p1;
    logic [BLOCKID_WIDTH-1:0] blockid_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        nonce_p1   <= nonce_p0;
        blockid_p1 <= blockid_p0;
    end

    // ---- stage 2: result FIFO ----
    logic [31:0]              mem_nonce [FIFO_DEPTH];
    logic [BLOCKID_WIDTH-1:0] mem_bid   [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic                     fifo_full;
    logic                     pop;
    logic                     push;

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign pop       = (count != '0) && res.result_ready;
    // A full queue still accepts a hit when the head leaves in the same cycle.
    assign push      = vld_p1 && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (vld_p1 && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_nonce[wr_ptr] <= nonce_p1;
            mem_bid[wr_ptr]   <= blockid_p1;
        end
    end

    // Head fields are forced to zero while empty so they are never X after reset.
    assign res.result_valid   = (count != '0);
    assign res.result_nonce   = res.result_valid ? mem_nonce[rd_ptr] : 32'd0;
    assign res.result_blockid = res.result_valid ? mem_bid[rd_ptr] : '0;

endmodule
